// File: rtl/wb_commit_pkg.sv
// wb_commit_pkg: shared types for the register-file write-commit unit.
//   REG_ADDR_W / NUM_REGS : integer register file geometry
//   XLEN                  : data width carried by commit_t
//   commit_t              : one pending write (destination + data)
//   scoreboard_t          : one pending bit per architectural register
package wb_commit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } commit_t;

  typedef logic [NUM_REGS-1:0] scoreboard_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// wb_ll_fifo: synchronous FIFO of commit_t entries for long-latency results.
// Ports:
//   clk, rst_n            : clock, async active-low reset (pointers/count only)
//   push_i, push_data_i   : write request and entry (ignored while full)
//   pop_i, pop_data_o     : read request (ignored while empty) and head entry
//   count_o, full_o, empty_o : occupancy status
// Push and pop may occur in the same cycle; full/empty reflect the registered
// count, so a push is refused while full even if a pop happens that cycle.
// DEPTH must be a power of two so pointers wrap naturally.
module wb_ll_fifo
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  commit_t                push_data_i,
  input  logic                   pop_i,
  output commit_t                pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  commit_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: sole driver of the integer register file write port.
// Merges in-order WB results (never stalled) with buffered long-latency
// results, tracks pending long-latency destinations and stalls ID on hazards.
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   wb_valid/wb_rd_addr/wb_rd_data    : pipeline WB result (always accepted)
//   ll_issue_valid/ll_issue_rd        : long-latency issue, marks rd pending
//   ll_resp_valid/ready/rd/data       : long-latency result handshake
//   id_rs1_addr/id_rs2_addr/id_rd_addr: ID-stage register addresses
//   stall_id                          : hold ID (RAW/WAW on pending register)
//   reg_write/rd_addr/rd_data         : registered register file write port
// Optional build macro WB_COMMIT_FWD_EN adds id_rs{1,2}_fwd(_data) bypass
// outputs for the write in flight and drops that term from stall_id.
// XLEN must equal wb_commit_pkg::XLEN (the FIFO entry type is built from it).
// When no write is committed, rd_addr/rd_data are driven to zero.
module wb_commit_unit #(
  parameter int LL_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            ll_issue_valid,
  input  logic [4:0]      ll_issue_rd,
  input  logic            ll_resp_valid,
  output logic            ll_resp_ready,
  input  logic [4:0]      ll_resp_rd,
  input  logic [XLEN-1:0] ll_resp_data,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  output logic            stall_id,
  output logic            reg_write,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data
`ifdef WB_COMMIT_FWD_EN
  ,
  output logic            id_rs1_fwd,
  output logic            id_rs2_fwd,
  output logic [XLEN-1:0] id_rs1_fwd_data,
  output logic [XLEN-1:0] id_rs2_fwd_data
`endif
);

  import wb_commit_pkg::commit_t;
  import wb_commit_pkg::scoreboard_t;

  localparam int CNT_W = $clog2(LL_DEPTH) + 1;

  commit_t          head, push_entry, sel;
  logic [CNT_W-1:0] ll_count;
  logic             ll_full, ll_empty, ll_push, ll_pop;
  scoreboard_t      pend_q, pend_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  logic             pend_hit;

  // Ready comes from the registered count, so a full FIFO refuses a push even
  // in a cycle where it also pops.
  assign ll_resp_ready   = (ll_count < CNT_W'(LL_DEPTH));
  assign ll_push         = ll_resp_valid && ll_resp_ready;
  assign ll_pop          = !wb_valid && !ll_empty;
  assign push_entry.rd   = ll_resp_rd;
  assign push_entry.data = ll_resp_data;

  wb_ll_fifo #(.DEPTH(LL_DEPTH)) u_ll_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ll_push),
    .push_data_i (push_entry),
    .pop_i       (ll_pop),
    .pop_data_o  (head),
    .count_o     (ll_count),
    .full_o      (ll_full),
    .empty_o     (ll_empty)
  );

  always_comb begin
    sel = head;
    if (wb_valid) begin
      sel.rd   = wb_rd_addr;
      sel.data = wb_rd_data;
    end
    // x0 commits still consume the FIFO entry but never reach the reg file.
    reg_write_d = (wb_valid || !ll_empty) && (sel.rd != '0);
    rd_addr_d   = reg_write_d ? sel.rd : '0;
    rd_data_d   = reg_write_d ? sel.data : '0;

    // Issue is applied after the pop clear so a same-cycle set wins.
    pend_d = pend_q;
    if (ll_pop)         pend_d[head.rd]     = 1'b0;
    if (ll_issue_valid) pend_d[ll_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      pend_q      <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      pend_q      <= pend_d;
    end
  end

  assign reg_write = reg_write_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;

  assign pend_hit = pend_q[id_rs1_addr] | pend_q[id_rs2_addr] | pend_q[id_rd_addr];

  // The pending bit drops one cycle before the reg file holds the value; the
  // write in flight is either bypassed or covered by one extra stall cycle.
  // reg_write_q implies rd_addr_q != 0, so x0 sources never match.
`ifdef WB_COMMIT_FWD_EN
  assign stall_id        = pend_hit;
  assign id_rs1_fwd      = reg_write_q && (rd_addr_q == id_rs1_addr);
  assign id_rs2_fwd      = reg_write_q && (rd_addr_q == id_rs2_addr);
  assign id_rs1_fwd_data = rd_data_q;
  assign id_rs2_fwd_data = rd_data_q;
`else
  assign stall_id = pend_hit |
                    (reg_write_q && ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr)));
`endif

endmodule
